// File: rtl/ni_packetizer_if.sv
// Signal bundle between a core, the NI packetizer and the router's local input port.
// slave = the packetizer; master = the core/router environment driving it.
interface ni_packetizer_if #(
    parameter int LEN_W = 4,
    parameter int CRD_W = 3
);
    logic             pkt_valid;
    logic             pkt_ready;
    logic [1:0]       pkt_dest_x;
    logic [1:0]       pkt_dest_y;
    logic [LEN_W-1:0] pkt_len;
    logic             data_valid;
    logic             data_ready;
    logic [5:0]       data_in;
    logic [7:0]       flit_out;
    logic             flit_valid;
    logic             credit_in;
    logic [CRD_W-1:0] credits;
    logic             busy;
    logic             pkt_err;

    modport slave (
        input  pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len, data_valid, data_in, credit_in,
        output pkt_ready, data_ready, flit_out, flit_valid, credits, busy, pkt_err
    );

    modport master (
        output pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len, data_valid, data_in, credit_in,
        input  pkt_ready, data_ready, flit_out, flit_valid, credits, busy, pkt_err
    );
endinterface

// File: rtl/ni_packetizer.sv
// Mesh NI injector: turns a packet request plus payload stream into header/body/tail
// flits for the router local port, throttled by credits for the router's input buffer.
module ni_packetizer #(
    parameter int X_NODE_NUM = 4,
    parameter int Y_NODE_NUM = 4,
    parameter int X_S_ADDR   = 0,
    parameter int Y_S_ADDR   = 1,
    parameter int BUF_DEPTH  = 4,
    parameter int CRD_W      = 3,
    parameter int LEN_W      = 4
) (
    input  logic           clk,
    input  logic           rst,
    ni_packetizer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(BUF_DEPTH);
    localparam logic [1:0]       SELF_X  = 2'(X_S_ADDR);
    localparam logic [1:0]       SELF_Y  = 2'(Y_S_ADDR);
    localparam logic [1:0]       T_HDR   = 2'b10;
    localparam logic [1:0]       T_BODY  = 2'b00;
    localparam logic [1:0]       T_TAIL  = 2'b01;

    state_t           state_q, state_d;
    logic [CRD_W-1:0] crd_q, crd_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       dx_q, dx_d;
    logic [1:0]       dy_q, dy_d;
    logic [7:0]       flit_q, flit_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    logic             send;
    logic             req_bad;
    logic             data_rdy;

    always_comb begin
        state_d = state_q;
        crd_d   = crd_q;
        rem_d   = rem_q;
        len_d   = len_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        flit_d  = flit_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        send    = 1'b0;

        // Self-addressed or off-mesh destinations and empty packets never enter the network.
        req_bad = (bus.pkt_len == '0)
               || (bus.pkt_dest_x == SELF_X && bus.pkt_dest_y == SELF_Y)
               || (32'(bus.pkt_dest_x) >= 32'(X_NODE_NUM))
               || (32'(bus.pkt_dest_y) >= 32'(Y_NODE_NUM));

        data_rdy = (state_q == BODY) && (crd_q != '0);

        case (state_q)
            IDLE: begin
                if (bus.pkt_valid) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        dx_d    = bus.pkt_dest_x;
                        dy_d    = bus.pkt_dest_y;
                        len_d   = bus.pkt_len;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (crd_q != '0) begin
                    flit_d  = {T_HDR, 2'b00, dx_q, dy_q};
                    fv_d    = 1'b1;
                    send    = 1'b1;
                    rem_d   = len_q;
                    state_d = BODY;
                end
            end
            BODY: begin
                if (bus.data_valid && data_rdy) begin
                    flit_d = {(rem_q == LEN_W'(1)) ? T_TAIL : T_BODY, bus.data_in};
                    fv_d   = 1'b1;
                    send   = 1'b1;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A returned credit and a send in the same cycle cancel out.
        case ({bus.credit_in, send})
            2'b10:   crd_d = (crd_q == CRD_MAX) ? crd_q : crd_q + CRD_W'(1);
            2'b01:   crd_d = crd_q - CRD_W'(1);
            default: crd_d = crd_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crd_q   <= CRD_MAX;
            rem_q   <= '0;
            len_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            flit_q  <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crd_q   <= crd_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            flit_q  <= flit_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign bus.pkt_ready  = (state_q == IDLE);
    assign bus.data_ready = data_rdy;
    assign bus.flit_out   = flit_q;
    assign bus.flit_valid = fv_q;
    assign bus.credits    = crd_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.pkt_err    = err_q;
endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: directed scenarios plus randomized packets checked against
// an expected-flit queue and a credit balance (BUF_DEPTH - flits in flight).
module tb_ni_packetizer;
    localparam int BUF_DEPTH = 4;
    localparam int LEN_W     = 4;
    localparam int CRD_W     = 3;

    logic clk = 1'b0;
    logic rst;

    ni_packetizer_if #(.LEN_W(LEN_W), .CRD_W(CRD_W)) ifc ();

    ni_packetizer #(
        .X_NODE_NUM(4), .Y_NODE_NUM(4), .X_S_ADDR(0), .Y_S_ADDR(1),
        .BUF_DEPTH(BUF_DEPTH), .CRD_W(CRD_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errs    = 0;
    logic [7:0] exp_q[$];
    int         sent;
    int         returned;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tk();
        @(negedge clk);
    endtask

    function automatic logic [7:0] hdr_flit(input logic [1:0] dx, input logic [1:0] dy);
        return {2'b10, 2'b00, dx, dy};
    endfunction

    task automatic req(input logic [1:0] dx, input logic [1:0] dy, input logic [3:0] len);
        ifc.pkt_valid  = 1'b1;
        ifc.pkt_dest_x = dx;
        ifc.pkt_dest_y = dy;
        ifc.pkt_len    = len;
    endtask

    // One random-phase cycle: check flits against the queue and credits against the
    // in-flight balance, then act as the router by returning credits at random.
    task automatic cyc();
        tk();
        if (ifc.flit_valid) begin
            sent++;
            if (exp_q.size() == 0) chk("rnd_flit_extra", 32'(ifc.flit_valid), 32'd0);
            else                   chk("rnd_flit", 32'(ifc.flit_out), 32'(exp_q.pop_front()));
        end
        chk("rnd_credits", 32'(ifc.credits), 32'(BUF_DEPTH - (sent - returned)));
        ifc.credit_in = 1'b0;
        if ((sent - returned) > 0 && $urandom_range(0, 2) != 0) begin
            ifc.credit_in = 1'b1;
            returned++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] d;
        logic [5:0] dt;
        rst            = 1'b1;
        ifc.pkt_valid  = 1'b0;
        ifc.pkt_dest_x = '0;
        ifc.pkt_dest_y = '0;
        ifc.pkt_len    = '0;
        ifc.data_valid = 1'b0;
        ifc.data_in    = '0;
        ifc.credit_in  = 1'b0;

        // Reset state
        repeat (2) tk();
        chk("rst_credits", 32'(ifc.credits), 32'd4);
        chk("rst_fv", 32'(ifc.flit_valid), 32'd0);
        chk("rst_ready", 32'(ifc.pkt_ready), 32'd1);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_err", 32'(ifc.pkt_err), 32'd0);
        rst = 1'b0;
        tk();

        // Basic packet (2,3) len 2 with a credit returned for each flit
        req(2'd2, 2'd3, 4'd2);
        tk();
        ifc.pkt_valid = 1'b0;
        chk("t2_acc_busy", 32'(ifc.busy), 32'd1);
        chk("t2_acc_fv", 32'(ifc.flit_valid), 32'd0);
        tk();
        chk("t2_hdr_fv", 32'(ifc.flit_valid), 32'd1);
        chk("t2_hdr", 32'(ifc.flit_out), 32'h8B);
        chk("t2_hdr_crd", 32'(ifc.credits), 32'd3);
        ifc.data_valid = 1'b1;
        ifc.data_in    = 6'h15;
        ifc.credit_in  = 1'b1;
        tk();
        chk("t2_body_fv", 32'(ifc.flit_valid), 32'd1);
        chk("t2_body", 32'(ifc.flit_out), 32'h15);
        chk("t2_body_crd", 32'(ifc.credits), 32'd3);
        ifc.data_in = 6'h2A;
        tk();
        chk("t2_tail_fv", 32'(ifc.flit_valid), 32'd1);
        chk("t2_tail", 32'(ifc.flit_out), 32'h6A);
        chk("t2_tail_busy", 32'(ifc.busy), 32'd0);
        chk("t2_tail_crd", 32'(ifc.credits), 32'd3);
        ifc.data_valid = 1'b0;
        tk();
        chk("t2_after_fv", 32'(ifc.flit_valid), 32'd0);
        chk("t2_after_crd", 32'(ifc.credits), 32'd4);
        tk();
        chk("crd_sat", 32'(ifc.credits), 32'd4);
        ifc.credit_in = 1'b0;

        // Credit stall: (3,0) len 5, data always valid, no credits returned
        req(2'd3, 2'd0, 4'd5);
        ifc.data_valid = 1'b1;
        tk();
        ifc.pkt_valid = 1'b0;
        tk();
        chk("t3_hdr", 32'(ifc.flit_out), 32'h8C);
        chk("t3_hdr_crd", 32'(ifc.credits), 32'd3);
        for (int i = 0; i < 3; i++) begin
            d = 6'($urandom);
            ifc.data_in = d;
            tk();
            chk("t3_body_fv", 32'(ifc.flit_valid), 32'd1);
            chk("t3_body", 32'(ifc.flit_out), 32'({2'b00, d}));
            chk("t3_body_crd", 32'(ifc.credits), 32'(2 - i));
        end
        d = 6'($urandom);
        ifc.data_in = d;
        tk();
        chk("t3_stall_fv", 32'(ifc.flit_valid), 32'd0);
        chk("t3_stall_drdy", 32'(ifc.data_ready), 32'd0);
        chk("t3_stall_crd", 32'(ifc.credits), 32'd0);
        chk("t3_stall_busy", 32'(ifc.busy), 32'd1);
        ifc.credit_in = 1'b1;
        tk();
        ifc.credit_in = 1'b0;
        chk("t3_pulse_fv", 32'(ifc.flit_valid), 32'd0);
        chk("t3_pulse_crd", 32'(ifc.credits), 32'd1);
        chk("t3_pulse_drdy", 32'(ifc.data_ready), 32'd1);
        tk();
        chk("t3_one_fv", 32'(ifc.flit_valid), 32'd1);
        chk("t3_one", 32'(ifc.flit_out), 32'({2'b00, d}));
        chk("t3_one_crd", 32'(ifc.credits), 32'd0);
        tk();
        chk("t3_one_only", 32'(ifc.flit_valid), 32'd0);
        ifc.credit_in = 1'b1;
        tk();
        dt = 6'($urandom);
        ifc.data_in = dt;
        tk();
        chk("t3_tail", 32'(ifc.flit_out), 32'({2'b01, dt}));
        chk("t3_tail_crd", 32'(ifc.credits), 32'd1);
        chk("t3_tail_busy", 32'(ifc.busy), 32'd0);
        repeat (3) tk();
        ifc.credit_in  = 1'b0;
        ifc.data_valid = 1'b0;
        chk("t3_restore_crd", 32'(ifc.credits), 32'd4);

        // Rejected requests
        req(2'd0, 2'd1, 4'd3);
        tk();
        ifc.pkt_valid = 1'b0;
        chk("t4_self_err", 32'(ifc.pkt_err), 32'd1);
        chk("t4_self_fv", 32'(ifc.flit_valid), 32'd0);
        chk("t4_self_busy", 32'(ifc.busy), 32'd0);
        chk("t4_self_crd", 32'(ifc.credits), 32'd4);
        tk();
        chk("t4_err_pulse", 32'(ifc.pkt_err), 32'd0);
        req(2'd1, 2'd1, 4'd0);
        tk();
        ifc.pkt_valid = 1'b0;
        chk("t4_len0_err", 32'(ifc.pkt_err), 32'd1);
        chk("t4_len0_ready", 32'(ifc.pkt_ready), 32'd1);
        tk();
        chk("t4_len0_fv", 32'(ifc.flit_valid), 32'd0);
        chk("t4_len0_idle", 32'(ifc.busy), 32'd0);

        // Credit returned during a send at credits=2 leaves the count at 2
        req(2'd1, 2'd2, 4'd3);
        ifc.data_valid = 1'b1;
        ifc.data_in    = 6'h01;
        tk();
        ifc.pkt_valid = 1'b0;
        tk();
        chk("t5_hdr", 32'(ifc.flit_out), 32'h86);
        tk();
        chk("t5_pre_crd", 32'(ifc.credits), 32'd2);
        ifc.credit_in = 1'b1;
        ifc.data_in   = 6'h02;
        tk();
        ifc.credit_in = 1'b0;
        chk("t5_simul_fv", 32'(ifc.flit_valid), 32'd1);
        chk("t5_simul_crd", 32'(ifc.credits), 32'd2);
        ifc.data_in = 6'h03;
        tk();
        chk("t5_tail", 32'(ifc.flit_out), 32'h43);
        ifc.data_valid = 1'b0;
        ifc.credit_in  = 1'b1;
        repeat (3) tk();
        ifc.credit_in = 1'b0;
        chk("t5_restore_crd", 32'(ifc.credits), 32'd4);

        // Reset in the middle of a packet
        req(2'd2, 2'd2, 4'd3);
        tk();
        ifc.pkt_valid = 1'b0;
        tk();
        chk("t6_hdr", 32'(ifc.flit_out), 32'h8A);
        rst = 1'b1;
        tk();
        rst = 1'b0;
        chk("t6_rst_busy", 32'(ifc.busy), 32'd0);
        chk("t6_rst_crd", 32'(ifc.credits), 32'd4);
        chk("t6_rst_fv", 32'(ifc.flit_valid), 32'd0);
        chk("t6_rst_ready", 32'(ifc.pkt_ready), 32'd1);
        d = 6'($urandom);
        req(2'd1, 2'd0, 4'd1);
        ifc.data_valid = 1'b1;
        ifc.data_in    = d;
        tk();
        ifc.pkt_valid = 1'b0;
        tk();
        chk("t6_hdr2", 32'(ifc.flit_out), 32'h84);
        tk();
        chk("t6_tail_fv", 32'(ifc.flit_valid), 32'd1);
        chk("t6_tail", 32'(ifc.flit_out), 32'({2'b01, d}));
        chk("t6_tail_busy", 32'(ifc.busy), 32'd0);
        ifc.data_valid = 1'b0;
        ifc.credit_in  = 1'b1;
        repeat (2) tk();
        ifc.credit_in = 1'b0;
        chk("t6_restore_crd", 32'(ifc.credits), 32'd4);

        // Randomized packets against the expected-flit queue and credit balance
        sent     = 0;
        returned = 0;
        for (int p = 0; p < 30; p++) begin
            logic [1:0] dx;
            logic [1:0] dy;
            logic [3:0] len;
            int         idx;
            int         guard;
            dx  = 2'($urandom_range(0, 3));
            dy  = 2'($urandom_range(0, 3));
            len = 4'($urandom_range(0, 7));
            if (p % 10 == 3) begin
                dx = 2'd0;
                dy = 2'd1;
            end
            req(dx, dy, len);
            cyc();
            ifc.pkt_valid = 1'b0;
            if (len == 4'd0 || (dx == 2'd0 && dy == 2'd1)) begin
                chk("rnd_err", 32'(ifc.pkt_err), 32'd1);
                continue;
            end
            chk("rnd_noerr", 32'(ifc.pkt_err), 32'd0);
            exp_q.push_back(hdr_flit(dx, dy));
            idx   = 0;
            guard = 0;
            while ((ifc.busy || exp_q.size() != 0) && guard < 500) begin
                if (idx < int'(len)) begin
                    ifc.data_valid = ($urandom_range(0, 3) != 0);
                    ifc.data_in    = 6'($urandom);
                end else begin
                    ifc.data_valid = 1'b0;
                end
                #1;
                if (ifc.data_valid && ifc.data_ready) begin
                    exp_q.push_back({(idx == int'(len) - 1) ? 2'b01 : 2'b00, ifc.data_in});
                    idx++;
                end
                cyc();
                guard++;
            end
            ifc.data_valid = 1'b0;
            chk("rnd_done_busy", 32'(ifc.busy), 32'd0);
            chk("rnd_drained", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (8) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/ni_packetizer.md
Name: ni_packetizer

Overview:
- Network-interface injector for one mesh node. It turns a core-side packet request plus a payload stream into header, body and tail flits for the router's local input port.
- The header carries the destination in exactly the field positions the router route-compute decodes: dest x in [3:2], dest y in [1:0].
- Injection is credit-based flow control against the router's local input buffer.

Parameters:
- X_NODE_NUM, 4, mesh width in nodes.
- Y_NODE_NUM, 4, mesh height in nodes.
- X_S_ADDR, 0, this node's x address.
- Y_S_ADDR, 1, this node's y address.
- BUF_DEPTH, 4, router local input buffer depth; this is also the initial credit count.
- CRD_W, 3, credit counter width; must hold BUF_DEPTH.
- LEN_W, 4, width of the payload-length field.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pkt_valid  in  1  packet request valid
- pkt_ready  out  1  request accepted when high with pkt_valid; combinational, =1 only in IDLE
- pkt_dest_x  in  2  destination x
- pkt_dest_y  in  2  destination y
- pkt_len  in  LEN_W  payload flit count (1..2^LEN_W-1)
- data_valid  in  1  payload word valid
- data_ready  out  1  payload accepted; combinational, = (state==BODY && credits!=0)
- data_in  in  6  payload word
- flit_out  out  8  flit to router local port
- flit_valid  out  1  flit_out valid, registered
- credit_in  in  1  one buffer slot freed by router
- credits  out  CRD_W  current credit count
- busy  out  1  state != IDLE
- pkt_err  out  1  one-cycle pulse: request rejected

Behaviour:
Flit format:
- [7:6] type: HDR=2'b10, BODY=2'b00, TAIL=2'b01.
- Header: {2'b10, 2'b00, dest_x, dest_y}.
- Body/tail: {type, data_in}.
- Packet = 1 header + pkt_len payload flits. The last payload flit is TAIL; the others are BODY.

Reset:
- state=IDLE, credits=BUF_DEPTH, flit_out=0, flit_valid=0, pkt_err=0, remaining count=0, latched dest=0.

State machine:
- IDLE:
  - On pkt_valid&&pkt_ready, check the request.
  - Reject if pkt_len==0, or dest==(X_S_ADDR,Y_S_ADDR), or dest_x>=X_NODE_NUM, or dest_y>=Y_NODE_NUM.
  - On reject: pkt_err=1 next cycle for one cycle, stay IDLE, no flit emitted.
  - Otherwise latch dest and len, go to HDR.
- HDR:
  - If credits!=0: at the next edge, flit_out=header, flit_valid=1, credits-1, remaining=len, go to BODY.
  - Else hold in HDR, flit_valid=0.
- BODY:
  - On data_valid&&data_ready: at the next edge, emit the payload flit (TAIL if remaining==1, else BODY), flit_valid=1, credits-1, remaining-1.
  - When the TAIL is emitted, go to IDLE.
  - If data_valid=0 or credits==0: flit_valid=0 and no state change.

Timing:
- flit_valid is high exactly one cycle per flit. No ready from the router; credits are the only backpressure.
- Latency from request acceptance to header on flit_out: 2 cycles (accept edge, then HDR edge), given credit is available.
- Back-to-back payload flits are allowed every cycle while credits last.
- After TAIL, the next request can be accepted in the following cycle (IDLE).

Credits:
- credit_in only: +1.
- Send only: -1.
- credit_in and send in the same cycle: count unchanged.
- credit_in while credits==BUF_DEPTH and no send: ignored; counter holds and never exceeds BUF_DEPTH.
- A send never occurs at credits==0.

Reset mid-packet:
- The packet is abandoned with no tail emitted. All state returns to reset values, with credits=BUF_DEPTH; the router is reset on the same rst.

Test Plan:
- Reset: assert rst 2 cycles -> credits=4, flit_valid=0, pkt_ready=1, busy=0, pkt_err=0.
- Packet dest (2,3) len 2, payload 0x15, 0x2A, credit_in returned each flit -> flits 0x8B, 0x15, 0x6A on three consecutive valid cycles; header 2 cycles after accept; busy drops after the tail.
- Credit stall: dest (3,0) len 5, data always valid, no credit_in -> header 0x8C plus 3 BODY flits, then data_ready=0 and flit_valid=0. One credit_in pulse -> exactly one more flit next cycle.
- Rejects: dest (0,1) len 3 -> pkt_err pulse 1 cycle, no flit, credits=4. dest (1,1) len 0 -> pkt_err; state stays IDLE.
- Simultaneous events: credit_in asserted in the same cycle as a flit send at credits=2 -> credits stays 2. credit_in at credits=4 with no send -> stays 4.
- Reset mid-packet: rst after header of a len-3 packet -> next cycle IDLE, credits=4, flit_valid=0. A new packet dest (1,0) len 1 -> flits 0x84, then TAIL {01,data}.
